// File: rtl/mips_cpu_regfile_sb.sv
// rtl/mips_cpu_regfile_sb.sv - register file with write bypass, load scoreboard and clear sweep
module mips_cpu_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              hazard_a,
  output logic              hazard_b,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pend;

  logic idle;
  logic wr_fire;
  logic pend_fire;
  logic byp_a, byp_b;

  // Qualify write and pending-set strobes: both are dead during a sweep and on the zero register
  always_comb begin
    idle      = (state == IDLE);
    wr_fire   = wr_en && idle && !(ZERO_REG && (wr_addr == '0));
    pend_fire = pend_set && idle && !(ZERO_REG && (pend_addr == '0));
  end

  // State register for the clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a sweep always runs for exactly DEPTH cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = SWEEP;
      SWEEP:   if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs
  always_comb begin
    clr_busy = (state == SWEEP);
  end

  // Sweep address counter, parked at zero outside a sweep so every sweep starts at r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= '0;
    else if (state == SWEEP && cnt != CNT_LAST) cnt <= cnt + 1'b1;
    else                                    cnt <= '0;
  end

  // Register storage: the sweep overrides any architectural write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == SWEEP) begin
      regs[cnt] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending-load scoreboard: set is applied after clear so a same-address set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (state == SWEEP) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_fire)   pend[wr_addr]   <= 1'b0;
      if (pend_fire) pend[pend_addr] <= 1'b1;
    end
  end

  // Combinational read ports with optional same-cycle forwarding from the write port
  always_comb begin
    byp_a = BYPASS && wr_en && idle && (wr_addr == rd_addr_a);
    byp_b = BYPASS && wr_en && idle && (wr_addr == rd_addr_b);

    if (ZERO_REG && (rd_addr_a == '0)) rd_data_a = '0;
    else if (byp_a)                    rd_data_a = wr_data;
    else                               rd_data_a = regs[rd_addr_a];

    if (ZERO_REG && (rd_addr_b == '0)) rd_data_b = '0;
    else if (byp_b)                    rd_data_b = wr_data;
    else                               rd_data_b = regs[rd_addr_b];

    if (ZERO_REG && (dbg_addr == '0))  dbg_data = '0;
    else                               dbg_data = regs[dbg_addr];
  end

  // RAW hazard flags: a pending register is satisfied only by a write arriving this cycle
  always_comb begin
    hazard_a = pend[rd_addr_a] && !(BYPASS && wr_en && (wr_addr == rd_addr_a));
    hazard_b = pend[rd_addr_b] && !(BYPASS && wr_en && (wr_addr == rd_addr_b));
  end

endmodule

// File: doc/mips_cpu_regfile_sb.md
Name: mips_cpu_regfile_sb

Overview:
Parametrised successor to the CPU's general-purpose register file. Provides two architectural read ports, one write port, a general debug read port, same-cycle write-to-read bypass, a pending-load scoreboard that flags RAW hazards, and a multi-cycle clear sequencer. Sits between the decode stage (reads, hazard check) and the writeback stage (writes, scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr_a  in  ADDR_W  read port A address (rs)
rd_data_a  out  DATA_W  read port A data
rd_addr_b  in  ADDR_W  read port B address (rt)
rd_data_b  out  DATA_W  read port B data
dbg_addr  in  ADDR_W  debug read address (for example, 2 to observe v0)
dbg_data  out  DATA_W  debug read data, never bypassed
pend_set  in  1  mark pend_addr as awaiting a load result
pend_addr  in  ADDR_W  register to mark pending
hazard_a  out  1  rd_addr_a is pending and not satisfied this cycle
hazard_b  out  1  rd_addr_b is pending and not satisfied this cycle
clr_req  in  1  start a clear sweep
clr_busy  out  1  clear sweep in progress

Behaviour:
- Reset: clk and rst_n; asynchronous, active-low. While rst_n=0: all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0. Resulting outputs: rd_data_a/b = 0, dbg_data = 0, hazard_a/b = 0, clr_busy = 0. Reset asserted mid-sweep aborts the sweep immediately.
- Write: on a rising edge with wr_en=1 in IDLE, reg[wr_addr] <= wr_data, visible to dbg_data the next cycle. With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational, zero latency. With BYPASS=1, if wr_en=1, state IDLE, wr_addr==rd_addr_x and the address is not the zero register, then rd_data_x = wr_data; otherwise rd_data_x = reg[rd_addr_x]. With ZERO_REG=1, address 0 always reads 0 on every port.
- Scoreboard: one pending bit per register.
  - At the edge, pend_set=1 sets pend[pend_addr].
  - At the edge, wr_en=1 clears pend[wr_addr].
  - Same address on both in one cycle: set wins.
  - pend_set to register 0 with ZERO_REG=1 is ignored.
  - hazard_x = pend[rd_addr_x] AND NOT (BYPASS=1 AND wr_en=1 AND wr_addr==rd_addr_x). This depends only on current state and inputs; the same-cycle pend_set does not affect it.
- Clear FSM, states IDLE and SWEEP:
  - IDLE and clr_req=1: go to SWEEP with cnt=0. The wr_en and pend_set of that cycle are still honoured.
  - SWEEP, each cycle: reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt+1. When cnt == DEPTH-1, go to IDLE and cnt <= 0.
  - Sweep length is exactly DEPTH cycles. clr_busy = 1 in SWEEP.
  - In SWEEP, wr_en, pend_set and clr_req are ignored, bypass is disabled, and reads return stored contents (mixed old and cleared values).
  - The upstream stage must stall while clr_busy = 1.
- Width rules: address comparisons are full ADDR_W, data is never truncated or extended, and cnt is ADDR_W+1 bits or wraps exactly at DEPTH-1.

Test Plan:
- Reset: hold rst_n=0, then release and read all 32 addresses on A/B/dbg -> all 0x00000000, hazard_a=hazard_b=0, clr_busy=0.
- Write/read and zero register: write 0xDEADBEEF to r5, read A=5 next cycle -> 0xDEADBEEF. Write 0x12345678 to r0, read A=0 -> 0. With dbg_addr=2 after writing 0xCAFEF00D to r2 -> dbg_data=0xCAFEF00D.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr_a=7 in the same cycle -> rd_data_a=0xA5A5A5A5 combinationally, while dbg_data (addr 7) still shows the old value. Repeat with BYPASS=0 -> rd_data_a shows the old value.
- Scoreboard:
  - pend_set r9, then read B=9 next cycle -> hazard_b=1.
  - Write r9 with 0x11 -> hazard_b=0 in that cycle and after.
  - pend_set r9 and write r9 in the same cycle -> r9=0x11 and hazard_b=1 afterwards.
  - pend_set r0 -> hazard never asserts.
- Clear sweep: fill r1..r31 with nonzero values and mark r3 pending, then pulse clr_req -> clr_busy=1 for exactly 32 cycles. A write to r4 during the sweep is dropped. Afterwards all registers = 0 and hazards are 0.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10 -> clr_busy drops immediately, all registers = 0, and a new write after release works normally.
